// File: rtl/cpu_pkg.sv
// Shared definitions for the LEGv8-style pipeline: datapath widths, zero register, WB bus.
package cpu_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned REG_AW = 5;
    localparam logic [REG_AW-1:0] XZR = 5'd31;

    typedef struct packed {
        logic [REG_AW-1:0] dest;
        logic [DATA_W-1:0] loaded;
        logic [DATA_W-1:0] result;
        logic              memtoreg;
        logic              regwrite;
    } wb_bus_t;

endpackage

// File: rtl/wb_mux.sv
// Write-back data select: load data or ALU result, full width, no extension.
module wb_mux
    import cpu_pkg::*;
#(
    parameter int unsigned Width = DATA_W
) (
    input  logic             sel_i,
    input  logic [Width-1:0] loaded_i,
    input  logic [Width-1:0] result_i,
    output logic [Width-1:0] data_o
);

    always_comb begin
        data_o = sel_i ? loaded_i : result_i;
    end

endmodule

// File: rtl/write_back_stage.sv
// WB stage: MEM/WB pipeline register, write-data select and qualified register-file write enable.
module write_back_stage
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] DestReg,
    input  logic [DATA_W-1:0] LoadedData,
    input  logic [DATA_W-1:0] Results,
    input  logic              MemToReg,
    input  logic              RegWrite,
    input  logic              Stall,
    input  logic              Flush,
    output logic [DATA_W-1:0] Data2Write,
    output logic [REG_AW-1:0] Reg2Write,
    output logic              oldRegWrite
);

    wb_bus_t wb_d;
    wb_bus_t wb_q;

    // Flush beats Stall: the bubble still captures data so only the write enable is killed.
    always_comb begin
        wb_d = wb_q;
        if (Flush || !Stall) begin
            wb_d.dest     = DestReg;
            wb_d.loaded   = LoadedData;
            wb_d.result   = Results;
            wb_d.memtoreg = MemToReg;
            wb_d.regwrite = Flush ? 1'b0 : RegWrite;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    wb_mux #(
        .Width (DATA_W)
    ) u_wb_mux (
        .sel_i    (wb_q.memtoreg),
        .loaded_i (wb_q.loaded),
        .result_i (wb_q.result),
        .data_o   (Data2Write)
    );

    always_comb begin
        Reg2Write   = wb_q.dest;
        oldRegWrite = wb_q.regwrite && (wb_q.dest != XZR);
    end

endmodule

// File: tb/tb_write_back_stage.sv
// Directed bench for write_back_stage with hand-computed expected outputs.
module tb_write_back_stage;

    logic        clk;
    logic        rst_n;
    logic [4:0]  DestReg;
    logic [63:0] LoadedData;
    logic [63:0] Results;
    logic        MemToReg;
    logic        RegWrite;
    logic        Stall;
    logic        Flush;
    logic [63:0] Data2Write;
    logic [4:0]  Reg2Write;
    logic        oldRegWrite;

    int vectors;
    int miscompares;

    write_back_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .DestReg     (DestReg),
        .LoadedData  (LoadedData),
        .Results     (Results),
        .MemToReg    (MemToReg),
        .RegWrite    (RegWrite),
        .Stall       (Stall),
        .Flush       (Flush),
        .Data2Write  (Data2Write),
        .Reg2Write   (Reg2Write),
        .oldRegWrite (oldRegWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] d, input logic [63:0] ld, input logic [63:0] res,
                         input logic m2r, input logic rw, input logic st, input logic fl);
        DestReg    = d;
        LoadedData = ld;
        Results    = res;
        MemToReg   = m2r;
        RegWrite   = rw;
        Stall      = st;
        Flush      = fl;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(5'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
                  1'b1, 1'b0, 1'b0);
            tick();
            vectors++;
            if (Data2Write !== 64'd0 || Reg2Write !== 5'd0 || oldRegWrite !== 1'b0) begin
                miscompares++;
                $display("FAIL reset[%0d]: got data=%h reg=%0d we=%b, want 0/0/0",
                         i, Data2Write, Reg2Write, oldRegWrite);
            end
        end
        drive(5'd12, 64'h1111, 64'h2222, 1'b0, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        tick();
        vectors++;
        if (Data2Write !== 64'h2222 || Reg2Write !== 5'd12 || oldRegWrite !== 1'b1) begin
            miscompares++;
            $display("FAIL first_capture: got data=%h reg=%0d we=%b, want 2222/12/1",
                     Data2Write, Reg2Write, oldRegWrite);
        end
        vectors++;
        if ($isunknown({Data2Write, Reg2Write, oldRegWrite})) begin
            miscompares++;
            $display("FAIL no_x: got data=%h reg=%h we=%b, want no X", Data2Write, Reg2Write,
                     oldRegWrite);
        end
    endtask

    task automatic test_alu_op();
        drive(5'd5, 64'hFFFF_0000_FFFF_0000, 64'h0000_0000_DEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        vectors++;
        if (Data2Write !== 64'hDEADBEEF || Reg2Write !== 5'd5 || oldRegWrite !== 1'b1) begin
            miscompares++;
            $display("FAIL alu_op: got data=%h reg=%0d we=%b, want deadbeef/5/1",
                     Data2Write, Reg2Write, oldRegWrite);
        end
    endtask

    task automatic test_load();
        drive(5'd9, 64'h0123_4567_89AB_CDEF, 64'h40, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        vectors++;
        if (Data2Write !== 64'h0123456789ABCDEF || Reg2Write !== 5'd9 || oldRegWrite !== 1'b1) begin
            miscompares++;
            $display("FAIL ldur: got data=%h reg=%0d we=%b, want 0123456789abcdef/9/1",
                     Data2Write, Reg2Write, oldRegWrite);
        end
        // Load data present but no write: value visible, enable low.
        drive(5'd3, 64'h8000_0000_0000_0001, 64'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        vectors++;
        if (Data2Write !== 64'h8000_0000_0000_0001 || Reg2Write !== 5'd3 || oldRegWrite !== 1'b0)
        begin
            miscompares++;
            $display("FAIL m2r_no_write: got data=%h reg=%0d we=%b, want 8000000000000001/3/0",
                     Data2Write, Reg2Write, oldRegWrite);
        end
    endtask

    task automatic test_xzr();
        drive(5'd31, 64'hABCD, 64'd7, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        vectors++;
        if (Data2Write !== 64'd7 || Reg2Write !== 5'd31 || oldRegWrite !== 1'b0) begin
            miscompares++;
            $display("FAIL xzr: got data=%h reg=%0d we=%b, want 7/31/0",
                     Data2Write, Reg2Write, oldRegWrite);
        end
        drive(5'd30, 64'hABCD, 64'd8, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        vectors++;
        if (Data2Write !== 64'd8 || Reg2Write !== 5'd30 || oldRegWrite !== 1'b1) begin
            miscompares++;
            $display("FAIL x30: got data=%h reg=%0d we=%b, want 8/30/1",
                     Data2Write, Reg2Write, oldRegWrite);
        end
    endtask

    task automatic test_store_flush();
        drive(5'd7, 64'h99, 64'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        vectors++;
        if (Data2Write !== 64'h1000 || Reg2Write !== 5'd7 || oldRegWrite !== 1'b0) begin
            miscompares++;
            $display("FAIL stur: got data=%h reg=%0d we=%b, want 1000/7/0",
                     Data2Write, Reg2Write, oldRegWrite);
        end
        drive(5'd4, 64'h77, 64'h4444, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        vectors++;
        if (Data2Write !== 64'h77 || Reg2Write !== 5'd4 || oldRegWrite !== 1'b0) begin
            miscompares++;
            $display("FAIL flush: got data=%h reg=%0d we=%b, want 77/4/0",
                     Data2Write, Reg2Write, oldRegWrite);
        end
        // Flush wins over Stall: data still captured, write killed.
        drive(5'd6, 64'h66, 64'h6060, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        vectors++;
        if (Data2Write !== 64'h6060 || Reg2Write !== 5'd6 || oldRegWrite !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_over_stall: got data=%h reg=%0d we=%b, want 6060/6/0",
                     Data2Write, Reg2Write, oldRegWrite);
        end
    endtask

    task automatic test_stall();
        drive(5'd10, 64'h0, 64'hCAFE, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(5'(20 + i), 64'(i + 1), 64'(100 + i), 1'($urandom), 1'(i[0]), 1'b1, 1'b0);
            tick();
            vectors++;
            if (Data2Write !== 64'hCAFE || Reg2Write !== 5'd10 || oldRegWrite !== 1'b1) begin
                miscompares++;
                $display("FAIL stall[%0d]: got data=%h reg=%0d we=%b, want cafe/10/1",
                         i, Data2Write, Reg2Write, oldRegWrite);
            end
        end
        drive(5'd11, 64'hBEEF, 64'h1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        vectors++;
        if (Data2Write !== 64'hBEEF || Reg2Write !== 5'd11 || oldRegWrite !== 1'b1) begin
            miscompares++;
            $display("FAIL unstall: got data=%h reg=%0d we=%b, want beef/11/1",
                     Data2Write, Reg2Write, oldRegWrite);
        end
    endtask

    task automatic test_async_reset();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (Data2Write !== 64'd0 || Reg2Write !== 5'd0 || oldRegWrite !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got data=%h reg=%0d we=%b, want 0/0/0",
                     Data2Write, Reg2Write, oldRegWrite);
        end
        drive(5'd2, 64'h5, 64'h6, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        #2 rst_n = 1'b1;
        vectors++;
        if (Data2Write !== 64'd0 || Reg2Write !== 5'd0 || oldRegWrite !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_hold: got data=%h reg=%0d we=%b, want 0/0/0",
                     Data2Write, Reg2Write, oldRegWrite);
        end
        tick();
        vectors++;
        if (Data2Write !== 64'h6 || Reg2Write !== 5'd2 || oldRegWrite !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_capture: got data=%h reg=%0d we=%b, want 6/2/1",
                     Data2Write, Reg2Write, oldRegWrite);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        drive(5'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_alu_op();
        test_load();
        test_xzr();
        test_store_flush();
        test_stall();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
